// File: rtl/cac_dec_arbiter.sv
// Round-robin arbiter sharing one registered CAC (Fibonacci-numeral) decoder among NREQ requesters.
// Owns the FNS weight table, which an iterative adder FSM regenerates from two seeds on request.
module cac_dec_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 8,
    parameter int WW   = 8,
    parameter int DW   = 8,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic [WW-1:0]        seed0,
    input  logic [WW-1:0]        seed1,
    output logic                 cfg_busy,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*CW-1:0]   req_code,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_data,
    input  logic                 rsp_ready
);

    // Handshake: a codeword moves on req_valid[i] & req_ready[i]; a result moves on
    // rsp_valid & rsp_ready. rsp_id/rsp_data hold steady while rsp_valid & !rsp_ready.

    localparam int KW = $clog2(CW);

    typedef enum logic {IDLE, GEN} state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic [KW-1:0]   km1;
    logic [KW-1:0]   km2;
    logic [WW-1:0]   w [CW];
    logic [IDW-1:0]  rr_ptr;

    logic            grant_ok;
    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW:0]    cand_sum;
    logic [IDW-1:0]  cand;
    logic [CW-1:0]   code_sel;
    logic [DW-1:0]   dec_sum;
    logic            xfer;

    // Default table entry j is the j-th Fibonacci weight (1,1,2,3,5,...) modulo 2^WW.
    function automatic logic [WW-1:0] fib_w(input int j);
        logic [WW-1:0] a;
        logic [WW-1:0] b;
        logic [WW-1:0] t;
        a = WW'(1);
        b = WW'(1);
        for (int n = 2; n <= j; n++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    assign cfg_busy = (state == GEN);
    assign km1      = k - KW'(1);
    assign km2      = k - KW'(2);

    // Rotating priority search starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_ok  = rst_n && (state == IDLE) && !cfg_start && (!rsp_valid || rsp_ready);
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand_sum = {1'b0, rr_ptr} + (IDW+1)'(off);
            if (cand_sum >= (IDW+1)'(NREQ))
                cand_sum = cand_sum - (IDW+1)'(NREQ);
            cand = cand_sum[IDW-1:0];
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        req_ready = '0;
        if (grant_ok && gnt_found)
            req_ready[gnt_idx] = 1'b1;
    end

    assign xfer = grant_ok && gnt_found;

    always_comb begin
        code_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i))
                code_sel = req_code[i*CW +: CW];
        end
        dec_sum = '0;
        for (int j = 0; j < CW; j++) begin
            if (code_sel[j])
                dec_sum = dec_sum + DW'(w[j]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            for (int j = 0; j < CW; j++)
                w[j] <= fib_w(j);
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        w[0]  <= seed0;
                        w[1]  <= seed1;
                        k     <= KW'(2);
                        state <= GEN;
                    end
                end
                GEN: begin
                    w[k] <= w[km1] + w[km2];
                    k    <= k + KW'(1);
                    if (k == KW'(CW-1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A new accept overwrites the draining result in the same cycle, so no bubble.
            if (xfer) begin
                rr_ptr    <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
                rsp_valid <= 1'b1;
                rsp_id    <= gnt_idx;
                rsp_data  <= dec_sum;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
